// File: rtl/vend_pkg.sv
// vend_pkg: FSM state encoding and coin codes shared by the vending controller
package vend_pkg;
  typedef enum logic [1:0] {COLLECT = 2'd0, VEND = 2'd1, RETURN = 2'd2} vend_state_e;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A    = 2'b01;
  localparam logic [1:0] COIN_B    = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;
endpackage

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin vending FSM; in clk/rst_n/coin/cancel/dispense_ack, out vend/change_out/coin_reject/credit
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE_UNITS      = 3,
  parameter int MAX_CREDIT_UNITS = 6,
  parameter int COIN_A_UNITS     = 1,
  parameter int COIN_B_UNITS     = 2,
  parameter int CREDIT_W         = $clog2(MAX_CREDIT_UNITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                dispense_ack,
  output logic                vend,
  output logic                change_out,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit
);
  localparam logic [CREDIT_W:0]   A_U   = (CREDIT_W + 1)'(COIN_A_UNITS);
  localparam logic [CREDIT_W:0]   B_U   = (CREDIT_W + 1)'(COIN_B_UNITS);
  localparam logic [CREDIT_W:0]   MAX_U = (CREDIT_W + 1)'(MAX_CREDIT_UNITS);
  localparam logic [CREDIT_W:0]   PRC_W = (CREDIT_W + 1)'(PRICE_UNITS);
  localparam logic [CREDIT_W-1:0] PRC   = CREDIT_W'(PRICE_UNITS);
  if (PRICE_UNITS < 1 || PRICE_UNITS > MAX_CREDIT_UNITS || MAX_CREDIT_UNITS < 2) begin : g_bad_price
    $error("vend_ctrl: illegal PRICE_UNITS/MAX_CREDIT_UNITS");
  end
  if (COIN_A_UNITS < 1 || COIN_A_UNITS > MAX_CREDIT_UNITS ||
      COIN_B_UNITS < 1 || COIN_B_UNITS > MAX_CREDIT_UNITS) begin : g_bad_coin
    $error("vend_ctrl: illegal coin values");
  end
  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coin_reject_q, coin_reject_d;
  logic [CREDIT_W:0]   sum;
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = coin != COIN_NONE;
    sum           = {1'b0, credit_q} + (coin == COIN_A ? A_U : coin == COIN_B ? B_U : '0);
    case (state_q)
      COLLECT: begin
        if (cancel) begin
          state_d = credit_q != '0 ? RETURN : COLLECT;
        end else if (coin != COIN_NONE && coin != COIN_BAD && sum <= MAX_U) begin
          coin_reject_d = 1'b0;
          credit_d      = sum[CREDIT_W-1:0];
          state_d       = sum >= PRC_W ? VEND : COLLECT;
        end
      end
      VEND: begin
        if (dispense_ack) begin
          credit_d = credit_q - PRC;
          state_d  = credit_q != PRC ? RETURN : COLLECT;
        end
      end
      RETURN: begin
        credit_d = credit_q - CREDIT_W'(1);
        state_d  = credit_q <= CREDIT_W'(1) ? COLLECT : RETURN;
      end
      default: state_d = COLLECT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
    end
  end
  assign vend        = state_q == VEND;
  assign change_out  = state_q == RETURN;
  assign coin_reject = coin_reject_q;
  assign credit      = credit_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed self-checking bench for default and PRICE=MAX=6 configurations
module tb_vend_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coin = 2'b00, coin2 = 2'b00;
  logic       cancel = 1'b0, ack = 1'b0, ack2 = 1'b0;
  logic       vend, change_out, coin_reject;
  logic       vend2, change_out2, coin_reject2;
  logic [2:0] credit, credit2;
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  vend_ctrl dut (
    .clk(clk), .rst_n(rst_n), .coin(coin), .cancel(cancel), .dispense_ack(ack),
    .vend(vend), .change_out(change_out), .coin_reject(coin_reject), .credit(credit)
  );
  vend_ctrl #(.PRICE_UNITS(6), .MAX_CREDIT_UNITS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .coin(coin2), .cancel(1'b0), .dispense_ack(ack2),
    .vend(vend2), .change_out(change_out2), .coin_reject(coin_reject2), .credit(credit2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic st(input string tag, input logic v, input logic c, input logic r, input logic [2:0] cr);
    chk({tag, ".vend"}, 32'(vend), 32'(v));
    chk({tag, ".change"}, 32'(change_out), 32'(c));
    chk({tag, ".reject"}, 32'(coin_reject), 32'(r));
    chk({tag, ".credit"}, 32'(credit), 32'(cr));
  endtask
  task automatic st6(input string tag, input logic v, input logic r, input logic [2:0] cr);
    chk({tag, ".vend"}, 32'(vend2), 32'(v));
    chk({tag, ".reject"}, 32'(coin_reject2), 32'(r));
    chk({tag, ".credit"}, 32'(credit2), 32'(cr));
    chk({tag, ".change"}, 32'(change_out2), 32'(0));
  endtask
  initial begin
    #2;
    st("rst", 0, 0, 0, 0);
    tick(); tick();
    st("rst_held", 0, 0, 0, 0);
    rst_n = 1'b1;
    coin = 2'b01; tick(); st("a1", 0, 0, 0, 1);
    tick(); st("a2", 0, 0, 0, 2);
    tick(); st("a3", 1, 0, 0, 3);
    coin = 2'b00; tick(); st("a_wait", 1, 0, 0, 3);
    ack = 1'b1; tick(); st("a_ack", 0, 0, 0, 0);
    ack = 1'b0; tick(); st("a_idle", 0, 0, 0, 0);
    coin = 2'b10; tick(); st("b1", 0, 0, 0, 2);
    tick(); st("b2", 1, 0, 0, 4);
    coin = 2'b00; ack = 1'b1; tick(); st("b_ack", 0, 1, 0, 1);
    ack = 1'b0; tick(); st("b_chg", 0, 0, 0, 0);
    coin = 2'b01; tick(); st("c1", 0, 0, 0, 1);
    coin = 2'b10; cancel = 1'b1; tick(); st("c_cancel", 0, 1, 1, 1);
    coin = 2'b00; cancel = 1'b0; tick(); st("c_done", 0, 0, 0, 0);
    coin = 2'b01; cancel = 1'b1; tick(); st("c0_cancel", 0, 0, 1, 0);
    coin = 2'b00; cancel = 1'b0; ack = 1'b1; tick(); st("ack_idle", 0, 0, 0, 0);
    ack = 1'b0;
    coin = 2'b10; tick(); st("d1", 0, 0, 0, 2);
    coin = 2'b11; tick(); st("d_bad", 0, 0, 1, 2);
    coin = 2'b00; tick(); st("d_clr", 0, 0, 0, 2);
    coin = 2'b01; tick(); st("d_vend", 1, 0, 0, 3);
    tick(); st("d_rejv", 1, 0, 1, 3);
    coin = 2'b11; tick(); st("d_rejv2", 1, 0, 1, 3);
    coin = 2'b00; cancel = 1'b1; tick(); st("d_cancelv", 1, 0, 0, 3);
    cancel = 1'b0; ack = 1'b1; tick(); st("d_ack", 0, 0, 0, 0);
    ack = 1'b0;
    coin = 2'b10; tick(); tick(); st("r_vend", 1, 0, 0, 4);
    coin = 2'b00; ack = 1'b1; tick(); st("r_ret", 0, 1, 0, 1);
    ack = 1'b0; rst_n = 1'b0; #1; st("r_async", 0, 0, 0, 0);
    tick(); rst_n = 1'b1;
    coin = 2'b01; tick(); st("r_after", 0, 0, 0, 1);
    coin = 2'b00; tick(); st6("p_idle", 0, 0, 0);
    coin2 = 2'b10; tick(); st6("p1", 0, 0, 2);
    tick(); st6("p2", 0, 0, 4);
    coin2 = 2'b01; tick(); st6("p3", 0, 0, 5);
    coin2 = 2'b10; tick(); st6("p_over", 0, 1, 5);
    coin2 = 2'b01; tick(); st6("p_full", 1, 0, 6);
    coin2 = 2'b00; ack2 = 1'b1; tick(); st6("p_ack", 0, 0, 0);
    ack2 = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
